// File: rtl/payload_server.sv
// payload_server: DDR-side payload responder for the packet-parser path.
// Write packets (command beat + data beats) are stored in a tagged slot
// buffer keyed by 32-bit packet id; single-beat read requests stream the
// stored payload back, tagged with packet id and requesting node.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_*                       Avalon-ST sink (requests and write payload)
//   out_*                      Avalon-ST source (payload responses)
//   o_payload_flag             high with every out_valid beat
//   o_pktid, o_dest            packet id / requesting node of current response
//   o_drop_cnt                 saturating count of dropped write packets
//
// Build option: define PAYLOAD_SERVER_KEEP_EN to keep a slot valid after it
// has been read (freed only by overwrite or reset).
module payload_server #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned NOC_RADIX  = 16,
    parameter int unsigned SLOTS      = 8,
    parameter int unsigned MAX_BEATS  = 16,
    localparam int unsigned SRC_W     = $clog2(NOC_RADIX),
    localparam int unsigned EMPTY_W   = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [EMPTY_W-1:0]    in_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [EMPTY_W-1:0]    out_empty,
    output logic                  out_error,
    output logic                  o_payload_flag,
    output logic [31:0]           o_pktid,
    output logic [SRC_W-1:0]      o_dest,
    output logic [15:0]           o_drop_cnt
);

    localparam int unsigned SLOT_W  = $clog2(SLOTS);
    localparam int unsigned IDX_W   = $clog2(MAX_BEATS);
    localparam int unsigned BEATS_W = IDX_W + 1;
    localparam int unsigned ADDR_W  = SLOT_W + IDX_W;

`ifdef PAYLOAD_SERVER_KEEP_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_DATA = 2'd1;
    localparam logic [1:0] S_WR_DROP = 2'd2;
    localparam logic [1:0] S_RD_SEND = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [SLOTS-1:0]                slot_valid_q, slot_valid_d;
    logic [SLOTS-1:0][31:0]          slot_pktid_q, slot_pktid_d;
    logic [SLOTS-1:0][BEATS_W-1:0]   slot_beats_q, slot_beats_d;
    logic [SLOTS-1:0][EMPTY_W-1:0]   slot_empty_q, slot_empty_d;
    logic [SLOTS-1:0]                slot_err_q, slot_err_d;
    logic [SLOT_W-1:0]               wr_slot_q, wr_slot_d;
    logic [BEATS_W-1:0]              wr_cnt_q, wr_cnt_d;
    logic [SLOT_W-1:0]               rd_slot_q, rd_slot_d;
    logic [IDX_W-1:0]                rd_idx_q, rd_idx_d;
    logic                            rd_miss_q, rd_miss_d;
    logic [15:0]                     drop_cnt_q, drop_cnt_d;
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]           out_data_q, out_data_d;
    logic                            out_sop_q, out_sop_d;
    logic                            out_eop_q, out_eop_d;
    logic [EMPTY_W-1:0]              out_empty_q, out_empty_d;
    logic                            out_error_q, out_error_d;
    logic                            flag_q, flag_d;
    logic [31:0]                     o_pktid_q, o_pktid_d;
    logic [SRC_W-1:0]                o_dest_q, o_dest_d;

    logic [DATA_WIDTH-1:0] mem [SLOTS*MAX_BEATS];
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;

    logic                  ld_en;
    logic [SLOT_W-1:0]     ld_slot;
    logic [IDX_W-1:0]      ld_idx;
    logic [ADDR_W-1:0]     ld_addr;

    logic                  accept;
    logic                  req_wr, req_rd;
    logic [31:0]           req_pktid;
    logic [SRC_W-1:0]      req_src;
    logic                  hit, free_any;
    logic [SLOT_W-1:0]     hit_slot, free_slot, wr_tgt;

    // Command beat field decode
    assign accept    = in_valid && in_ready_q;
    assign req_wr    = in_data[DATA_WIDTH-1];
    assign req_rd    = in_data[DATA_WIDTH-2];
    assign req_pktid = in_data[DATA_WIDTH-3 -: 32];
    assign req_src   = in_data[DATA_WIDTH-35 -: SRC_W];

    // Tag match and lowest free slot; descending loop so the lowest index wins
    always_comb begin : lookup
        hit       = 1'b0;
        hit_slot  = '0;
        free_any  = 1'b0;
        free_slot = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_valid_q[i] && (slot_pktid_q[i] == req_pktid)) begin
                hit      = 1'b1;
                hit_slot = SLOT_W'(i);
            end
            if (!slot_valid_q[i]) begin
                free_any  = 1'b1;
                free_slot = SLOT_W'(i);
            end
        end
        wr_tgt = hit ? hit_slot : free_slot;
    end

    // Next-state and next-output logic
    always_comb begin : next_state
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_pktid_d = slot_pktid_q;
        slot_beats_d = slot_beats_q;
        slot_empty_d = slot_empty_q;
        slot_err_d   = slot_err_q;
        wr_slot_d    = wr_slot_q;
        wr_cnt_d     = wr_cnt_q;
        rd_slot_d    = rd_slot_q;
        rd_idx_d     = rd_idx_q;
        rd_miss_d    = rd_miss_q;
        drop_cnt_d   = drop_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_empty_d  = out_empty_q;
        out_error_d  = out_error_q;
        o_pktid_d    = o_pktid_q;
        o_dest_d     = o_dest_q;
        mem_we       = 1'b0;
        mem_waddr    = {wr_slot_q, wr_cnt_q[IDX_W-1:0]};
        ld_en        = 1'b0;
        ld_slot      = rd_slot_q;
        ld_idx       = '0;

        case (state_q)
            S_IDLE: begin
                if (accept && in_sop) begin
                    if (req_wr && !req_rd && !in_eop) begin
                        if (hit || free_any) begin
                            wr_slot_d              = wr_tgt;
                            wr_cnt_d               = '0;
                            slot_valid_d[wr_tgt]   = 1'b0;
                            slot_err_d[wr_tgt]     = 1'b0;
                            slot_pktid_d[wr_tgt]   = req_pktid;
                            state_d                = S_WR_DATA;
                        end else begin
                            state_d = S_WR_DROP;
                        end
                    end else if (!req_wr && req_rd && in_eop) begin
                        o_pktid_d = req_pktid;
                        o_dest_d  = req_src;
                        rd_idx_d  = '0;
                        state_d   = S_RD_SEND;
                        if (hit) begin
                            rd_slot_d = hit_slot;
                            rd_miss_d = 1'b0;
                            ld_en     = 1'b1;
                            ld_slot   = hit_slot;
                        end else begin
                            rd_miss_d   = 1'b1;
                            out_valid_d = 1'b1;
                            out_data_d  = '0;
                            out_sop_d   = 1'b1;
                            out_eop_d   = 1'b1;
                            out_empty_d = '0;
                            out_error_d = 1'b1;
                        end
                    end
                end
            end
            S_WR_DATA: begin
                if (accept) begin
                    // Beats past slot capacity are discarded and flag the slot
                    if (wr_cnt_q < BEATS_W'(MAX_BEATS)) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + BEATS_W'(1);
                    end else begin
                        slot_err_d[wr_slot_q] = 1'b1;
                    end
                    if (in_eop) begin
                        slot_valid_d[wr_slot_q] = 1'b1;
                        slot_beats_d[wr_slot_q] = wr_cnt_d;
                        slot_empty_d[wr_slot_q] = in_empty;
                        state_d                 = S_IDLE;
                    end
                end
            end
            S_WR_DROP: begin
                if (accept && in_eop) begin
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_RD_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (out_eop_q) begin
                        out_valid_d = 1'b0;
                        out_sop_d   = 1'b0;
                        out_eop_d   = 1'b0;
                        out_empty_d = '0;
                        out_error_d = 1'b0;
                        state_d     = S_IDLE;
                        if (!rd_miss_q && !KEEP) begin
                            slot_valid_d[rd_slot_q] = 1'b0;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                        ld_en    = 1'b1;
                        ld_slot  = rd_slot_q;
                        ld_idx   = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Present a stored beat on the output registers
        ld_addr = {ld_slot, ld_idx};
        if (ld_en) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[ld_addr];
            out_sop_d   = (ld_idx == '0);
            out_eop_d   = (BEATS_W'(ld_idx) == (slot_beats_q[ld_slot] - BEATS_W'(1)));
            out_empty_d = out_eop_d ? slot_empty_q[ld_slot] : '0;
            out_error_d = slot_err_q[ld_slot];
        end

        flag_d     = out_valid_d;
        in_ready_d = (state_d != S_RD_SEND);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            slot_valid_q <= '0;
            slot_pktid_q <= '0;
            slot_beats_q <= '0;
            slot_empty_q <= '0;
            slot_err_q   <= '0;
            wr_slot_q    <= '0;
            wr_cnt_q     <= '0;
            rd_slot_q    <= '0;
            rd_idx_q     <= '0;
            rd_miss_q    <= 1'b0;
            drop_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_empty_q  <= '0;
            out_error_q  <= 1'b0;
            flag_q       <= 1'b0;
            o_pktid_q    <= '0;
            o_dest_q     <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_pktid_q <= slot_pktid_d;
            slot_beats_q <= slot_beats_d;
            slot_empty_q <= slot_empty_d;
            slot_err_q   <= slot_err_d;
            wr_slot_q    <= wr_slot_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_slot_q    <= rd_slot_d;
            rd_idx_q     <= rd_idx_d;
            rd_miss_q    <= rd_miss_d;
            drop_cnt_q   <= drop_cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_empty_q  <= out_empty_d;
            out_error_q  <= out_error_d;
            flag_q       <= flag_d;
            o_pktid_q    <= o_pktid_d;
            o_dest_q     <= o_dest_d;
        end
    end

    // Payload storage; contents are only meaningful behind a valid slot tag
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= in_data;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_sop        = out_sop_q;
    assign out_eop        = out_eop_q;
    assign out_empty      = out_empty_q;
    assign out_error      = out_error_q;
    assign o_payload_flag = flag_q;
    assign o_pktid        = o_pktid_q;
    assign o_dest         = o_dest_q;
    assign o_drop_cnt     = drop_cnt_q;

endmodule
